// File: rtl/shift_operand_stage.sv
// shift_operand_stage
//   Two-entry operand stage in front of the 16-bit barrel rotator.
//   S1 reads the operands, with forwarding, and registers the rotator
//   inputs. S2 captures the rotator result and presents it to writeback.
//   A rotate-right is turned into the equivalent rotate-left amount.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     decode handshake
//   in_op                 00 ROL reg, 01 ROR reg, 10 ROL imm, 11 ROR imm
//   in_rd/in_rs/in_rt     destination, data source, amount source
//   in_imm                immediate rotate amount
//   rf_raddr_a/b          register file read addresses (in_rs / in_rt)
//   rf_rdata_a/b          register file read data, same cycle
//   wb_valid/addr/data    writeback bus, used for forwarding
//   rot_din/rot_amount    registered rotator inputs
//   rot_dout              rotator result (combinational)
//   out_valid/out_ready   result handshake to writeback
//   out_rd/out_data       presented destination and result
module shift_operand_stage #(
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [RA_W-1:0] in_rd,
  input  logic [RA_W-1:0] in_rs,
  input  logic [RA_W-1:0] in_rt,
  input  logic [3:0]      in_imm,
  output logic [RA_W-1:0] rf_raddr_a,
  output logic [RA_W-1:0] rf_raddr_b,
  input  logic [15:0]     rf_rdata_a,
  input  logic [15:0]     rf_rdata_b,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [15:0]     wb_data,
  output logic [15:0]     rot_din,
  output logic [15:0]     rot_amount,
  input  logic [15:0]     rot_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RA_W-1:0] out_rd,
  output logic [15:0]     out_data
);

  logic            s1_valid;
  logic [RA_W-1:0] s1_rd;

  logic            s2_free;
  logic            s1_adv;
  logic            hazard;
  logic            accept;
  logic [15:0]     rs_val;
  logic [15:0]     rt_val;
  logic [3:0]      raw_k;
  logic [3:0]      rol_k;

  assign rf_raddr_a = in_rs;
  assign rf_raddr_b = in_rt;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  // The S1 entry has no result yet, so a consumer of it must wait until
  // it reaches S2, even when S1 is advancing this very cycle.
  assign hazard   = s1_valid &&
                    ((s1_rd == in_rs) || (!in_op[1] && (s1_rd == in_rt)));
  assign in_ready = (!s1_valid || s1_adv) && !hazard;
  assign accept   = in_valid && in_ready;

  // Operand select: S2 result first, then the writeback bus, then the RF.
  always_comb begin
    rs_val = rf_rdata_a;
    if (out_valid && (out_rd == in_rs))
      rs_val = out_data;
    else if (wb_valid && (wb_addr == in_rs))
      rs_val = wb_data;

    rt_val = rf_rdata_b;
    if (out_valid && (out_rd == in_rt))
      rt_val = out_data;
    else if (wb_valid && (wb_addr == in_rt))
      rt_val = wb_data;
  end

  // Rotate right by k equals rotate left by (16 - k) mod 16.
  always_comb begin
    raw_k = in_op[1] ? in_imm : rt_val[3:0];
    rol_k = raw_k;
    if (in_op[0])
      rol_k = ~raw_k + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      rot_din    <= '0;
      rot_amount <= '0;
      s1_rd      <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      rot_din    <= rs_val;
      rot_amount <= {12'b0, rol_k};
      s1_rd      <= in_rd;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= rot_dout;
      out_rd    <= s1_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_operand_stage.sv
// tb_shift_operand_stage
//   Directed bench for shift_operand_stage. Provides a register file model
//   and the downstream rotator, queues the expected result of every issued
//   instruction and compares each handshaked output against the queue.
module tb_shift_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic [3:0]  in_imm;
  logic [2:0]  rf_raddr_a;
  logic [2:0]  rf_raddr_b;
  logic [15:0] rf_rdata_a;
  logic [15:0] rf_rdata_b;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] rot_din;
  logic [15:0] rot_amount;
  logic [15:0] rot_dout;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_rd;
  logic [15:0] out_data;

  logic [15:0] rf [8];
  logic [31:0] rot_dbl;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks;
  int   n_pass;
  int   w;

  shift_operand_stage #(.RA_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rot_din    (rot_din),
    .rot_amount (rot_amount),
    .rot_dout   (rot_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_data   (out_data)
  );

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];
  assign rot_dbl    = {rot_din, rot_din} << rot_amount[3:0];
  assign rot_dout   = rot_dbl[31:16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_rd", 32'(out_rd), 32'(mon_e.rd));
        chk("out_data", 32'(out_data), 32'(mon_e.data));
      end
    end
  end

  task automatic present(input logic [1:0] op, input int rd, input int rs,
                         input int rt, input int imm, input logic [15:0] exp);
    exp_t e;
    in_op    = op;
    in_rd    = 3'(rd);
    in_rs    = 3'(rs);
    in_rt    = 3'(rt);
    in_imm   = 4'(imm);
    in_valid = 1'b1;
    e.rd     = 3'(rd);
    e.data   = exp;
    sb.push_back(e);
  endtask

  task automatic accept(output int waits);
    bit ok;
    ok    = 0;
    waits = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      waits++;
    end
    if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Issue one instruction; exp_amt / exp_din < 0 skips that S1 check.
  task automatic issue(input logic [1:0] op, input int rd, input int rs,
                       input int rt, input int imm, input logic [15:0] exp,
                       input int exp_amt, input int exp_din, input int exp_waits);
    int wt;
    present(op, rd, rs, rt, imm, exp);
    accept(wt);
    if (exp_waits >= 0) chk("stall_cycles", 32'(wt), 32'(exp_waits));
    if (exp_amt >= 0)   chk("rot_amount", 32'(rot_amount), 32'(exp_amt));
    if (exp_din >= 0)   chk("rot_din", 32'(rot_din), 32'(exp_din));
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_rd     = '0;
    in_rs     = '0;
    in_rt     = '0;
    in_imm    = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_rot_amount", 32'(rot_amount), 32'd0);
    chk("reset_rot_din", 32'(rot_din), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ROL imm 1 of 0x8001, latency check
    rf[1] = 16'h8001;
    issue(2'b10, 2, 1, 0, 1, 16'h0003, 1, 16'h8001, 0);
    chk("latency_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_data", 32'(out_data), 32'h0003);
    chk("latency_rd", 32'(out_rd), 32'd2);
    drain();

    // ROR conversion, including ROR 0, back to back
    rf[1] = 16'h0001;
    issue(2'b11, 3, 1, 0, 4, 16'h1000, 12, 16'h0001, 0);
    issue(2'b11, 4, 1, 0, 0, 16'h0001, 0, 16'h0001, 0);
    drain();

    // Register amount, high bits of rt ignored
    rf[1] = 16'h1234;
    rf[3] = 16'hFFF5;
    issue(2'b00, 6, 1, 3, 0, 16'h4682, 5, 16'h1234, 0);
    drain();

    // ROR by register: 0x1234 ror 5 == rol 11
    rf[3] = 16'h0005;
    issue(2'b01, 6, 1, 3, 0, 16'hA091, 11, 16'h1234, 0);
    drain();

    // Dependency: second instruction stalls one cycle and forwards from S2
    rf[2] = 16'h0000;
    issue(2'b10, 2, 1, 0, 4, 16'h2341, 4, 16'h1234, 0);
    issue(2'b10, 5, 2, 0, 4, 16'h3412, 4, 16'h2341, 1);
    drain();

    // Backpressure with three instructions
    rf[1] = 16'h0001;
    out_ready = 1'b0;
    issue(2'b10, 2, 1, 0, 1, 16'h0002, 1, -1, 0);
    issue(2'b10, 3, 1, 0, 2, 16'h0004, 2, -1, 0);
    present(2'b10, 4, 1, 0, 3, 16'h0008);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h0002);
      chk("bp_out_rd", 32'(out_rd), 32'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    accept(w);
    chk("bp_release_stall", 32'(w), 32'd0);
    @(negedge clk);
    chk("bp_drain2_valid", 32'(out_valid), 32'd1);
    chk("bp_drain2_rd", 32'(out_rd), 32'd3);
    @(negedge clk);
    chk("bp_drain3_valid", 32'(out_valid), 32'd1);
    chk("bp_drain3_rd", 32'(out_rd), 32'd4);
    drain();

    // Writeback forwarding, then S2 beating the writeback bus
    rf[1]    = 16'h0000;
    rf[2]    = 16'h5555;
    wb_valid = 1'b1;
    wb_addr  = 3'd1;
    wb_data  = 16'h00F0;
    issue(2'b10, 2, 1, 0, 4, 16'h0F00, 4, 16'h00F0, 0);
    wb_addr  = 3'd2;
    wb_data  = 16'hDEAD;
    issue(2'b10, 4, 2, 0, 4, 16'hF000, 4, 16'h0F00, 1);
    wb_valid = 1'b0;
    drain();

    // Reset with both entries full
    rf[1] = 16'h1234;
    out_ready = 1'b0;
    issue(2'b10, 2, 1, 0, 1, 16'h2468, 1, -1, 0);
    issue(2'b10, 3, 1, 0, 2, 16'h48D0, 2, -1, 0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_rot_amount", 32'(rot_amount), 32'd0);
    chk("midrst_rot_din", 32'(rot_din), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_operand_stage.md
# shift_operand_stage

Two-entry pipelined operand stage that sits directly upstream of the 16-bit barrel rotator. It accepts decoded rotate instructions, fetches operands from the register file with writeback forwarding, and converts rotate-right into an equivalent rotate-left amount. It registers `din`/`amount` for the rotator, captures the rotator's combinational result in a result register, and hands the result to writeback over a valid/ready interface.

## Interface
- `RA_W`, default 3: register address width (8 architectural registers).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_op`  in  2  operation: 00 ROL by register, 01 ROR by register, 10 ROL by immediate, 11 ROR by immediate.
- `in_rd`, `in_rs`, `in_rt`  in  RA_W each  destination, data source, amount source (`in_rt` used only for register forms).
- `in_imm`  in  4  immediate rotate amount.
- `rf_raddr_a`, `rf_raddr_b`  out  RA_W  register file read addresses; driven combinationally as `in_rs` and `in_rt`.
- `rf_rdata_a`, `rf_rdata_b`  in  16  register file read data; combinational read, same cycle.
- `wb_valid`, `wb_addr`, `wb_data`  in  1/RA_W/16  writeback bus, used for forwarding.
- `rot_din`  out  16  registered operand to the rotator.
- `rot_amount`  out  16  registered left-rotate amount to the rotator. Bits [15:4] are always 0.
- `rot_dout`  in  16  rotator result; combinational from `rot_din`/`rot_amount`.
- `out_valid`, `out_ready`  out/in  1  result handshake to writeback.
- `out_rd`  out  RA_W  destination of the presented result.
- `out_data`  out  16  presented result.

## Operation
**Pipeline registers**
- S1 holds operands: `s1_valid`, `rot_din`, `rot_amount`, `s1_rd`.
- S2 holds the result: `out_valid`, `out_data`, `out_rd`.

**Advance rules**
- `s2_free = !out_valid || out_ready`.
- `s1_adv = s1_valid && s2_free`.
- S2 loads `rot_dout` and `s1_rd` when `s1_adv` is high.
- When `out_ready` is high and S1 is not advancing, `out_valid` clears.

**Hazard**
- `hazard = s1_valid && (s1_rd == in_rs || (in_op[1]==0 && s1_rd == in_rt))`.
- S1's result does not exist yet, so a matching instruction stalls.

**Accept**
- `in_ready = (!s1_valid || s1_adv) && !hazard`.
- S1 loads on `in_valid && in_ready`. Otherwise, if `s1_adv` is high, `s1_valid` clears.

**Operand select** (per source: rs, and rt for register forms), highest priority first:
1. S2 forwarding: `out_valid && out_rd == src` gives `out_data`.
2. Writeback forwarding: `wb_valid && wb_addr == src` gives `wb_data`.
3. Otherwise the register file read data.

**Amount**
- Raw amount `k` is `in_imm` (forms 1x) or the selected rt value [3:0] (forms 0x). The rt value's bits [15:4] are ignored.
- ROL: `rot_amount = {12'b0, k}`.
- ROR: `rot_amount = {12'b0, (16 - k) mod 16}`, i.e. `(~k + 1) & 4'hF`. ROR 0 therefore gives amount 0.

**Reset**
- Asynchronously clears `s1_valid`, `out_valid`, `rot_din`, `rot_amount`, `s1_rd`, `out_data` and `out_rd` to 0.
- `in_ready` reads 1 immediately after reset.
- Reset mid-operation discards both entries. No result for a discarded entry is ever presented.

## Timing
- Latency: instruction accepted at edge E, result loaded into S2 and `out_valid` high after edge E+1, assuming `out_ready` was held high.
- Throughput: one instruction per cycle with no hazards and `out_ready` held high.
- Backpressure: while `out_valid && !out_ready`, `out_data`/`out_rd` hold stable. S1 holds, and `in_ready` is 0 when S1 is full.
- Simultaneous drain and fill: with both S1 and S2 valid and `out_ready=1`, S2 takes S1's result and S1 takes a new instruction in the same edge with no bubble, provided there is no hazard.
- Hazard stall: a dependent instruction stalls exactly until its producer moves into S2, then forwards from S2. The penalty is one cycle.
- Same-cycle write and forward: if `wb_valid` targets the source in the accept cycle, `wb_data` is used even though the register file still returns the old value.
- S2 forwarding beats `wb_data` when both match.

## Test plan
- Reset, then ROL-imm: r1=0x8001, ROL imm 1, rd=r2 → `rot_amount`=1, `out_data`=0x0003, `out_rd`=2, two edges after accept.
- ROR conversion: r1=0x0001; ROR imm 4 → `rot_amount`=12, `out_data`=0x1000. ROR imm 0 → `rot_amount`=0, `out_data`=0x0001.
- Register amount with ignored high bits: r3=0xFFF5, ROL r1=0x1234 by r3 → `rot_amount`=5, `out_data`=0x4682.
- Back-to-back dependency: ROL r2←r1 by 4 (r1=0x1234), then ROL r5←r2 by 4 → `in_ready`=0 for one cycle, the second instruction forwards 0x2341 from S2, and its `out_data`=0x3412.
- Backpressure: hold `out_ready`=0 with three instructions issued → S2 and S1 fill, `in_ready`=0, and `out_data` stays stable. Release `out_ready` → results drain in order, one per cycle.
- Writeback forwarding: `wb_valid`=1, `wb_addr`=r1, `wb_data`=0x00F0 while the register file returns 0 → ROL r1 by 4 gives 0x0F00. Assert `rst` with both entries full → `out_valid`=0 immediately, with no stale output after release.
